seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/hex_to_seg.sv | 12 +
 rtl/seven_seg_scanner.sv | 101 ++++++++++
 tb/tb_seven_seg_scanner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Segment codes are active-low {a,b,c,d,e,f,g}.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int   NUM_DIGITS = 8;
  localparam seg_t SEG_BLANK  = 7'h7F;

  localparam seg_t SEG_LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment decoder.
// Pure table lookup, no state.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment driver with a
// frame-aligned double buffer and per-slot blanking.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [7:0]  an_o,
  output seg_t        seg_o,
  output logic        dp_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] pre;
  logic [2:0]    idx;

  logic [31:0] act_data;
  logic [7:0]  act_dp;
  logic [7:0]  act_en;
  logic [31:0] pend_data;
  logic [7:0]  pend_dp;
  logic [7:0]  pend_en;
  logic        pend_valid;

  logic        tick;
  logic        wrap;
  logic        blank;
  logic [3:0]  nib;
  seg_t        nib_seg;

  assign tick  = (pre == LAST);
  assign wrap  = tick && (idx == 3'd7);
  assign nib   = act_data[{idx, 2'b00} +: 4];
  assign blank = (pre < BLANK) || !act_en[idx];

  assign busy_o = pend_valid;

  hex_to_seg u_dec (
    .nibble (nib),
    .seg    (nib_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre          <= '0;
      idx          <= '0;
      act_data     <= '0;
      act_dp       <= '0;
      act_en       <= '0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_en      <= '0;
      pend_valid   <= 1'b0;
      frame_done_o <= 1'b0;
      an_o         <= 8'hFF;
      seg_o        <= SEG_BLANK;
      dp_o         <= 1'b1;
    end else begin
      pre          <= tick ? '0 : pre + 1'b1;
      frame_done_o <= wrap;
      if (tick)
        idx <= idx + 3'd1;

      // A load landing on the wrap bypasses the pending stage.
      if (wrap) begin
        if (load_i) begin
          act_data <= data_i;
          act_dp   <= dp_i;
          act_en   <= en_i;
        end else if (pend_valid) begin
          act_data <= pend_data;
          act_dp   <= pend_dp;
          act_en   <= pend_en;
        end
        pend_valid <= 1'b0;
      end else if (load_i) begin
        pend_data  <= data_i;
        pend_dp    <= dp_i;
        pend_en    <= en_i;
        pend_valid <= 1'b1;
      end

      an_o  <= blank ? 8'hFF : ~(8'h01 << idx);
      seg_o <= blank ? SEG_BLANK : nib_seg;
      dp_o  <= blank ? 1'b1 : ~act_dp[idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard plus directed-vector bench for seven_seg_scanner.
// Runs with REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_seven_seg_scanner;

  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  en = '0;
  logic        busy;
  logic        fdone;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_out;

  seven_seg_scanner #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .data_i       (data),
    .dp_i         (dp_in),
    .en_i         (en),
    .busy_o       (busy),
    .frame_done_o (fdone),
    .an_o         (an),
    .seg_o        (seg),
    .dp_o         (dp_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       fd;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dp;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  logic [6:0] hexlut [16];

  int errors = 0;
  int checks = 0;

  obs_t q[$];

  int          m_pre, m_idx;
  logic [31:0] m_adata, m_pdata;
  logic [7:0]  m_aen, m_pen, m_adp, m_pdp;
  logic        m_pv;
  int          last_pre, last_idx;
  logic        last_wrap;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_idx = 0;
    m_adata = '0; m_pdata = '0;
    m_aen = '0; m_pen = '0; m_adp = '0; m_pdp = '0;
    m_pv = 1'b0;
  endtask

  task automatic step();
    obs_t e;
    obs_t a;
    bit   bl;
    bit   w;
    last_wrap = 1'b0;
    if (!rst_n) begin
      model_reset();
      e = '{busy:1'b0, fd:1'b0, an:8'hFF, seg:7'h7F, dp:1'b1};
      last_pre = -1; last_idx = -1;
    end else begin
      bl = (m_pre < BC) || !m_aen[m_idx];
      e.an  = bl ? 8'hFF : ~(8'h01 << m_idx);
      e.seg = bl ? 7'h7F : hexlut[m_adata[m_idx*4 +: 4]];
      e.dp  = bl ? 1'b1 : ~m_adp[m_idx];
      w = (m_pre == RD - 1) && (m_idx == 7);
      e.fd = w;
      if (w) begin
        if (load) begin
          m_adata = data; m_aen = en; m_adp = dp_in;
        end else if (m_pv) begin
          m_adata = m_pdata; m_aen = m_pen; m_adp = m_pdp;
        end
        m_pv = 1'b0;
      end else if (load) begin
        m_pdata = data; m_pen = en; m_pdp = dp_in; m_pv = 1'b1;
      end
      e.busy = m_pv;
      last_pre = m_pre; last_idx = m_idx; last_wrap = w;
      if (m_pre == RD - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    a = '{busy:busy, fd:fdone, an:an, seg:seg, dp:dp_out};
    e = q.pop_front();
    chk("scoreboard", 32'(a), 32'(e));
  endtask

  task automatic goto_slot(input int d, input int p);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(last_idx == d && last_pre == p) && n < 80);
    if (n >= 80) chk("goto_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_wrap();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_wrap && n < 80);
    if (n >= 80) chk("wrap_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e,
                         input logic [7:0] p);
    data = d; en = e; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    int cnt, cnt2;
    bit w;
    hexlut = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    tbl[0]  = '{32'h76543210, 8'hFF, 8'h00, 0, 8'hFE, 7'h01, 1'b1};
    tbl[1]  = '{32'h76543210, 8'hFF, 8'h00, 3, 8'hF7, 7'h06, 1'b1};
    tbl[2]  = '{32'h76543210, 8'hFF, 8'h00, 7, 8'h7F, 7'h0F, 1'b1};
    tbl[3]  = '{32'h76543210, 8'hFF, 8'h00, 4, 8'hEF, 7'h4C, 1'b1};
    tbl[4]  = '{32'hFEDCBA98, 8'h81, 8'h80, 0, 8'hFE, 7'h00, 1'b1};
    tbl[5]  = '{32'hFEDCBA98, 8'h81, 8'h80, 7, 8'h7F, 7'h38, 1'b0};
    tbl[6]  = '{32'hFEDCBA98, 8'h81, 8'h80, 3, 8'hFF, 7'h7F, 1'b1};
    tbl[7]  = '{32'h89ABCDEF, 8'hFF, 8'h04, 2, 8'hFB, 7'h42, 1'b0};
    tbl[8]  = '{32'h89ABCDEF, 8'hFF, 8'h04, 5, 8'hDF, 7'h08, 1'b1};
    tbl[9]  = '{32'h89ABCDEF, 8'hFF, 8'h04, 6, 8'hBF, 7'h04, 1'b1};
    tbl[10] = '{32'h89ABCDEF, 8'hFF, 8'h04, 1, 8'hFD, 7'h30, 1'b1};
    tbl[11] = '{32'h89ABCDEF, 8'hFF, 8'h04, 4, 8'hEF, 7'h60, 1'b1};

    model_reset();
    // Reset for three clocks, then two dark frames.
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_busy", 32'(busy), 32'h0);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (an != 8'hFF) cnt++;
    end
    chk("dark_frames", 32'(cnt), 32'd0);

    // First load, then frame_done cadence.
    step(); step();
    do_load(32'h76543210, 8'hFF, 8'h00);
    chk("busy_after_load", 32'(busy), 32'h1);
    wait_wrap();
    step();
    chk("busy_after_wrap", 32'(busy), 32'h0);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (fdone) cnt++;
      if (an == 8'hFF) cnt2++;
    end
    chk("frame_done_pulses", 32'(cnt), 32'd2);
    chk("blank_cycles", 32'(cnt2), 32'd16);

    // Directed digit/segment vectors.
    for (int i = 0; i < 12; i++) begin
      data = tbl[i].data; en = tbl[i].en; dp_in = tbl[i].dp; load = 1'b1;
      step();
      w = last_wrap;
      load = 1'b0;
      if (!w) wait_wrap();
      goto_slot(tbl[i].digit, 1);
      chk($sformatf("vec%0d_an", i), 32'(an), 32'(tbl[i].an));
      chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(tbl[i].seg));
      chk($sformatf("vec%0d_dp", i), 32'(dp_out), 32'(tbl[i].dpo));
    end

    // Double buffer: A then B in one frame; only B shows.
    goto_slot(2, 1);
    do_load(32'h11111111, 8'hFF, 8'h00);
    goto_slot(5, 2);
    do_load(32'h22222222, 8'hFF, 8'h00);
    wait_wrap();
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (seg == 7'h4F) cnt++;
      if (seg == 7'h12) cnt2++;
    end
    chk("dbuf_no_a", 32'(cnt), 32'd0);
    chk("dbuf_b_lit", 32'(cnt2), 32'd24);

    // Load on the exact wrap cycle.
    goto_slot(7, 2);
    data = 32'h00000005; en = 8'h01; dp_in = 8'h01; load = 1'b1;
    step();
    load = 1'b0;
    chk("wrap_load_is_wrap", 32'(last_wrap), 32'h1);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (busy) cnt++;
    end
    chk("wrap_load_busy", 32'(cnt), 32'd0);
    chk("wrap_load_seg", 32'(seg), 32'h24);
    chk("wrap_load_an", 32'(an), 32'hFE);
    chk("wrap_load_dp", 32'(dp_out), 32'h0);

    // Reset mid-frame with a pending value.
    goto_slot(3, 1);
    do_load(32'h33333333, 8'hFF, 8'h00);
    chk("pend_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_an", 32'(an), 32'hFF);
    chk("midrst_busy", 32'(busy), 32'h0);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (an != 8'hFF) cnt++;
    end
    chk("midrst_dark", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
